// File: rtl/edabk_transmitter_cfg.sv
// Parametrised UART transmitter: start, data (LSB/MSB first), optional parity, 1-2 stop bits.
// Accepts a word only in IDLE (tx_ready); finish pulses in the first IDLE cycle after the last stop bit.
module edabk_transmitter_cfg #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  bclk,
  input  logic                  reset_n,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_in,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  finish
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 2;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (CLK_DIV < 1) begin : g_err_clk_div
    $error("edabk_transmitter_cfg: CLK_DIV must be >= 1");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_err_data_width
    $error("edabk_transmitter_cfg: DATA_WIDTH must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop_bits
    $error("edabk_transmitter_cfg: STOP_BITS must be 1 or 2");
  end
  if (PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
      MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_err_flags
    $error("edabk_transmitter_cfg: PARITY_EN, PARITY_ODD and MSB_FIRST must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [BW-1:0]         r_bit;
  logic [BW-1:0]         w_bit_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [DATA_WIDTH-1:0] w_shift_adv;
  logic                  r_parity;
  logic                  w_parity_nxt;
  logic                  r_tx_out;
  logic                  w_tx_out_nxt;
  logic                  r_finish;
  logic                  w_finish_nxt;
  logic                  w_tc;
  logic                  w_data_bit;

  assign w_tc        = (r_cnt == CNT_LAST);
  assign w_data_bit  = (MSB_FIRST != 0) ? r_shift[DATA_WIDTH-1] : r_shift[0];
  assign w_shift_adv = (MSB_FIRST != 0) ? {r_shift[DATA_WIDTH-2:0], 1'b0}
                                        : {1'b0, r_shift[DATA_WIDTH-1:1]};

  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx_out <= 1'b1;
      r_finish <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
      r_tx_out <= w_tx_out_nxt;
      r_finish <= w_finish_nxt;
    end
  end

  // tx_out is loaded with the level of the bit being entered, so it lines up with the state register.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = w_tc ? '0 : r_cnt + 1'b1;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_tx_out_nxt = r_tx_out;
    w_finish_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt    = '0;
        w_tx_out_nxt = 1'b1;
        if (tx_valid) begin
          w_state_nxt  = S_START;
          w_shift_nxt  = tx_in;
          w_parity_nxt = (^tx_in) ^ (PARITY_ODD != 0);
          w_bit_nxt    = '0;
          w_tx_out_nxt = 1'b0;
        end
      end
      S_START: begin
        if (w_tc) begin
          w_state_nxt  = S_DATA;
          w_bit_nxt    = '0;
          w_tx_out_nxt = w_data_bit;
          w_shift_nxt  = w_shift_adv;
        end
      end
      S_DATA: begin
        if (w_tc) begin
          if (r_bit == DATA_LAST) begin
            w_bit_nxt = '0;
            if (PARITY_EN != 0) begin
              w_state_nxt  = S_PARITY;
              w_tx_out_nxt = r_parity;
            end else begin
              w_state_nxt  = S_STOP;
              w_tx_out_nxt = 1'b1;
            end
          end else begin
            w_bit_nxt    = r_bit + 1'b1;
            w_tx_out_nxt = w_data_bit;
            w_shift_nxt  = w_shift_adv;
          end
        end
      end
      S_PARITY: begin
        if (w_tc) begin
          w_state_nxt  = S_STOP;
          w_bit_nxt    = '0;
          w_tx_out_nxt = 1'b1;
        end
      end
      S_STOP: begin
        w_tx_out_nxt = 1'b1;
        if (w_tc) begin
          if (r_bit == STOP_LAST) begin
            w_state_nxt  = S_IDLE;
            w_bit_nxt    = '0;
            w_finish_nxt = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_cnt_nxt    = '0;
        w_tx_out_nxt = 1'b1;
      end
    endcase
  end

  assign tx_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign tx_out   = r_tx_out;
  assign finish   = r_finish;

endmodule

// File: tb/tb_edabk_transmitter_cfg.sv
// Directed bench for edabk_transmitter_cfg: six differently configured instances share one clock;
// expected line levels are queued per frame and compared cycle by cycle.
module tb_edabk_transmitter_cfg;

  logic       bclk;
  logic       rst_n;
  logic       vld  [6];
  logic [7:0] din  [5];
  logic [4:0] din5;
  logic       rdy  [6];
  logic       txo  [6];
  logic       bsy  [6];
  logic       fin  [6];

  int n_vec = 0;
  int n_err = 0;
  logic exp_q[$];

  // Per-instance configuration, mirrored from the parameter overrides below.
  int cfg_div [6] = '{4, 4, 4, 4, 1, 4};
  int cfg_dw  [6] = '{8, 8, 8, 8, 8, 5};
  int cfg_pen [6] = '{0, 1, 1, 0, 1, 0};
  int cfg_podd[6] = '{0, 0, 1, 0, 1, 0};
  int cfg_stop[6] = '{1, 1, 1, 1, 2, 2};
  int cfg_msb [6] = '{0, 0, 0, 1, 1, 0};

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  edabk_transmitter_cfg #(.CLK_DIV(4)) u0 (
    .bclk(bclk), .reset_n(rst_n), .tx_valid(vld[0]), .tx_ready(rdy[0]), .tx_in(din[0]),
    .tx_out(txo[0]), .busy(bsy[0]), .finish(fin[0]));
  edabk_transmitter_cfg #(.CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .bclk(bclk), .reset_n(rst_n), .tx_valid(vld[1]), .tx_ready(rdy[1]), .tx_in(din[1]),
    .tx_out(txo[1]), .busy(bsy[1]), .finish(fin[1]));
  edabk_transmitter_cfg #(.CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .bclk(bclk), .reset_n(rst_n), .tx_valid(vld[2]), .tx_ready(rdy[2]), .tx_in(din[2]),
    .tx_out(txo[2]), .busy(bsy[2]), .finish(fin[2]));
  edabk_transmitter_cfg #(.CLK_DIV(4), .MSB_FIRST(1)) u3 (
    .bclk(bclk), .reset_n(rst_n), .tx_valid(vld[3]), .tx_ready(rdy[3]), .tx_in(din[3]),
    .tx_out(txo[3]), .busy(bsy[3]), .finish(fin[3]));
  edabk_transmitter_cfg #(.CLK_DIV(1), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2),
                          .MSB_FIRST(1)) u4 (
    .bclk(bclk), .reset_n(rst_n), .tx_valid(vld[4]), .tx_ready(rdy[4]), .tx_in(din[4]),
    .tx_out(txo[4]), .busy(bsy[4]), .finish(fin[4]));
  edabk_transmitter_cfg #(.CLK_DIV(4), .DATA_WIDTH(5), .STOP_BITS(2)) u5 (
    .bclk(bclk), .reset_n(rst_n), .tx_valid(vld[5]), .tx_ready(rdy[5]), .tx_in(din5),
    .tx_out(txo[5]), .busy(bsy[5]), .finish(fin[5]));

  task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s u%0d: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  task automatic drive(input int idx, input logic v, input logic [7:0] w);
    vld[idx] = v;
    if (idx == 5) din5 = w[4:0];
    else din[idx] = w;
  endtask

  task automatic push_level(input logic lvl, input int div);
    for (int j = 0; j < div; j++) exp_q.push_back(lvl);
  endtask

  // Called #1 after a rising edge in the cycle the word is to be accepted (cycle 0).
  // hold=1 keeps tx_valid high with nxt so the next word is accepted in the finish cycle.
  task automatic run_frame(input int idx, input logic [7:0] word, input bit hold, input logic [7:0] nxt);
    int   c;
    int   div;
    logic b;
    logic p;
    div = cfg_div[idx];
    drive(idx, 1'b1, word);
    chk("ready_at_accept", idx, rdy[idx], 1);
    push_level(1'b0, div);
    p = 1'b0;
    for (int i = 0; i < cfg_dw[idx]; i++) begin
      b = (cfg_msb[idx] != 0) ? word[cfg_dw[idx]-1-i] : word[i];
      p = p ^ word[i];
      push_level(b, div);
    end
    if (cfg_pen[idx] != 0) push_level((cfg_podd[idx] != 0) ? ~p : p, div);
    push_level(1'b1, div * cfg_stop[idx]);
    @(posedge bclk); #1;
    c = 1;
    while (exp_q.size() > 0) begin
      if (c == 1) begin
        if (hold) drive(idx, 1'b1, nxt);
        else drive(idx, 1'b0, word);
      end
      if (!hold && c == 3 * div) drive(idx, 1'b0, ~word);
      b = exp_q.pop_front();
      chk("tx_out", idx, txo[idx], b);
      chk("ready_busy", idx, rdy[idx], 0);
      chk("busy", idx, bsy[idx], 1);
      chk("no_early_finish", idx, fin[idx], 0);
      @(posedge bclk); #1;
      c++;
    end
    chk("finish_pulse", idx, fin[idx], 1);
    chk("ready_after", idx, rdy[idx], 1);
    chk("idle_line", idx, txo[idx], 1);
    chk("busy_after", idx, bsy[idx], 0);
  endtask

  task automatic idle_cycle(input int idx);
    @(posedge bclk); #1;
    chk("finish_single", idx, fin[idx], 0);
    chk("idle_hold", idx, txo[idx], 1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) drive(i, 1'b0, 8'h00);
    repeat (3) @(posedge bclk);
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("rst_tx_out", i, txo[i], 1);
      chk("rst_ready", i, rdy[i], 1);
      chk("rst_busy", i, bsy[i], 0);
      chk("rst_finish", i, fin[i], 0);
    end
    rst_n = 1'b1;
    @(posedge bclk); #1;
    chk("post_rst_finish", 0, fin[0], 0);

    run_frame(0, 8'h55, 1'b0, 8'h00);
    idle_cycle(0);
    run_frame(1, 8'h07, 1'b0, 8'h00);
    idle_cycle(1);
    run_frame(1, 8'h00, 1'b0, 8'h00);
    idle_cycle(1);
    run_frame(2, 8'h07, 1'b0, 8'h00);
    idle_cycle(2);
    run_frame(3, 8'h80, 1'b0, 8'h00);
    idle_cycle(3);
    run_frame(0, 8'hA3, 1'b1, 8'h3C);
    run_frame(0, 8'h3C, 1'b0, 8'h00);
    idle_cycle(0);
    run_frame(5, 8'h1F, 1'b0, 8'h00);
    idle_cycle(5);
    run_frame(4, 8'hC6, 1'b0, 8'h00);
    idle_cycle(4);
    run_frame(4, 8'h01, 1'b0, 8'h00);
    idle_cycle(4);

    // Abort a frame of 0xA5 in data bit 3 (cycles 17..20 after accept).
    drive(0, 1'b1, 8'hA5);
    @(posedge bclk); #1;
    drive(0, 1'b0, 8'hA5);
    repeat (17) begin
      @(posedge bclk); #1;
    end
    chk("pre_abort_bit3", 0, txo[0], 0);
    chk("pre_abort_busy", 0, bsy[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_tx_out", 0, txo[0], 1);
    chk("abort_busy", 0, bsy[0], 0);
    chk("abort_finish", 0, fin[0], 0);
    chk("abort_ready", 0, rdy[0], 1);
    @(posedge bclk); #1;
    chk("abort_hold_finish", 0, fin[0], 0);
    rst_n = 1'b1;
    run_frame(0, 8'h3C, 1'b0, 8'h00);
    idle_cycle(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
